// File: rtl/riscv_pkg.sv
// Shared constants for the mini RISC-V core: load opcode, load funct3 codes and
// the writeback state encoding.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  // True when funct3 names a supported load and the address is aligned for its width.
  function automatic logic load_legal(input logic [2:0] funct3, input logic [1:0] addr_low);
    case (funct3)
      F3_LB, F3_LBU: load_legal = 1'b1;
      F3_LH, F3_LHU: load_legal = (addr_low[0] == 1'b0);
      F3_LW:         load_legal = (addr_low == 2'b00);
      default:       load_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: shifts the aligned word down to the
// addressed byte/halfword and sign- or zero-extends it to 32 bits.
module load_extend
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addrLow,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addrLow, 3'b000};
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  data = {24'h000000, shifted[7:0]};
      F3_LHU:  data = {16'h0000, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: drives the decoder register write port from execute results
// and load responses, stalling execute while a load is outstanding.
//
// state        | meaning
// WB_IDLE      | ready for a new execute result (ex_ready=1)
// WB_WAIT_LOAD | load accepted, waiting on mem_rvalid or timeout (ex_ready=0)
module writeback_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_regWrite,
  input  logic        ex_isLoad,
  input  logic [2:0]  ex_funct3,
  input  logic [1:0]  ex_addrLow,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        regWrite,
  output logic [4:0]  rd,
  output logic [31:0] writeData,
  output logic        load_err
);

  wb_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       rd_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_low_q;
  logic [31:0]      load_data;

  load_extend u_load_extend (
    .rdata   (mem_rdata),
    .addrLow (addr_low_q),
    .funct3  (funct3_q),
    .data    (load_data)
  );

  assign ex_ready = (state == WB_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WB_IDLE;
      cnt        <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      addr_low_q <= '0;
      regWrite   <= 1'b0;
      rd         <= '0;
      writeData  <= '0;
      load_err   <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      load_err <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (ex_valid) begin
            if (!ex_isLoad) begin
              regWrite  <= ex_regWrite && (ex_rd != 5'd0);
              rd        <= ex_rd;
              writeData <= ex_result;
            end else if (!load_legal(ex_funct3, ex_addrLow)) begin
              load_err <= 1'b1;
            end else begin
              rd_q       <= ex_rd;
              funct3_q   <= ex_funct3;
              addr_low_q <= ex_addrLow;
              cnt        <= '0;
              state      <= WB_WAIT_LOAD;
            end
          end
        end
        WB_WAIT_LOAD: begin
          // A response in the final waiting cycle still wins over the timeout.
          if (mem_rvalid) begin
            regWrite  <= (rd_q != 5'd0);
            rd        <= rd_q;
            writeData <= load_data;
            state     <= WB_IDLE;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            load_err <= 1'b1;
            state    <= WB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule
